dmem_ctrl: RTL and testbench

- Parametrised successor to the processor's word-only data memory.
- Adds byte/half/word access with sign or zero extension, little-endian byte-lane writes, a valid/ready request and response handshake, and configurable wait-state latency.
- Sits between the core's load/store stage and on-chip SRAM storage; one transaction is in flight at a time.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/dmem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte/half/word data-memory controller.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and shifted write data for stores,
// lane extraction plus sign/zero extension for loads. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              unsigned_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [WORD_W-1:0] rword_i,
    output logic [3:0]        be_o,
    output logic [WORD_W-1:0] wdata_o,
    output logic [WORD_W-1:0] rdata_o
);

    size_e       sz;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign sz = size_e'(size_i);

    // Store path: data is replicated across lanes, the enables pick the real ones
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        case (sz)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = '0;
            end
        endcase
    end

    always_comb begin
        byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_o  = '0;
        case (sz)
            SZ_BYTE: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response, byte/half/word access, wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [WORD_W-1:0]   mem_q [DEPTH_WORDS];

    logic                accept;
    logic                commit;
    logic                src_req;
    logic                c_we;
    logic [ADDR_W-1:0]   c_addr;
    logic [1:0]          c_size;
    logic                c_uns;
    logic [WORD_W-1:0]   c_wdata;
    logic [ADDR_W-3:0]   c_word;
    logic [IDX_W-1:0]    c_idx;
    logic                c_oor;
    logic                c_rsvd;
    logic                c_mis;
    logic                c_err;
    logic                mem_we;
    logic [WORD_W-1:0]   raw_word;
    logic [3:0]          be;
    logic [WORD_W-1:0]   wdata_al;
    logic [WORD_W-1:0]   ld_data;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit uses the live request on the accept edge
    assign src_req = (state_q == ST_IDLE);
    assign c_we    = src_req ? req_we       : we_q;
    assign c_addr  = src_req ? req_addr     : addr_q;
    assign c_size  = src_req ? req_size     : size_q;
    assign c_uns   = src_req ? req_unsigned : uns_q;
    assign c_wdata = src_req ? req_wdata    : wdata_q;

    // DEPTH_WORDS is a power of two, so any bit above the index means out of range
    assign c_word = c_addr[ADDR_W-1:2];
    assign c_idx  = c_word[IDX_W-1:0];
    assign c_oor  = (c_word >> IDX_W) != '0;
    assign c_rsvd = (size_e'(c_size) == SZ_RSVD);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign c_mis = ((size_e'(c_size) == SZ_HALF) && c_addr[0]) ||
                   ((size_e'(c_size) == SZ_WORD) && (c_addr[1:0] != 2'b00));
`else
    assign c_mis = 1'b0;
`endif

    assign c_err    = c_oor || c_rsvd || c_mis;
    assign raw_word = mem_q[c_idx];
    assign mem_we   = commit && c_we && !c_err;

    dmem_lane_align u_align (
        .size_i     (c_size),
        .addr_lo_i  (c_addr[1:0]),
        .unsigned_i (c_uns),
        .wdata_i    (c_wdata),
        .rword_i    (raw_word),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_LD;
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_we) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields are only meaningful after an accept; no reset needed
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[c_idx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table driven through a response scoreboard,
// plus hand-written back-pressure and mid-operation reset sequences.
module tb_dmem_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;
    localparam int WS    = 1;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wdata; v.exp_rd = erd; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           input logic [31:0] erd, input logic eerr,
                           input int stall, input bit intrude, input string nm);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, " accept-timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rd = erd; e.err = eerr;
        exp_q.push_back(e);
        n = 1;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) begin
            chk({nm, " rsp-timeout"}, 32'(rsp_valid), 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        chk({nm, " latency"}, 32'(n), 32'(WS + 1));
        for (int i = 0; i < stall; i++) begin
            chk($sformatf("%s stall%0d valid", nm, i), 32'(rsp_valid), 32'd1);
            chk($sformatf("%s stall%0d rdata", nm, i), rsp_rdata, exp_q[0].rd);
            chk($sformatf("%s stall%0d ready", nm, i), 32'(req_ready), 32'd0);
            if (intrude) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
                req_size = W; req_wdata = 32'h0;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        chk({nm, " rdata"}, rsp_rdata, e.rd);
        chk({nm, " err"}, 32'(rsp_err), 32'(e.err));
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({nm, " released"}, 32'(rsp_valid), 32'd0);
        chk({nm, " idle-ready"}, 32'(req_ready), 32'd1);
    endtask

    logic [31:0] word10_final;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add(1, 32'h0,    W, 0, 32'hCAFEF00D, 32'h0,        0);
        add(1, 32'h10,   W, 0, 32'hDEADBEEF, 32'h0,        0);
        add(0, 32'h10,   W, 0, 32'h0,        32'hDEADBEEF, 0);
        add(1, 32'h11,   B, 0, 32'hAAAAAA7F, 32'h0,        0);
        add(0, 32'h10,   W, 0, 32'h0,        32'hDEAD7FEF, 0);
        add(0, 32'h13,   B, 0, 32'h0,        32'hFFFFFFDE, 0);
        add(0, 32'h13,   B, 1, 32'h0,        32'h000000DE, 0);
        add(0, 32'h10,   H, 0, 32'h0,        32'h00007FEF, 0);
        add(0, 32'h11,   B, 0, 32'h0,        32'h0000007F, 0);
        add(0, 32'h10,   W, 1, 32'h0,        32'hDEAD7FEF, 0);
        add(0, 32'h1000, W, 0, 32'h0,        32'h0,        1);
        add(1, 32'h1000, W, 0, 32'h11111111, 32'h0,        1);
        add(0, 32'h0,    W, 0, 32'h0,        32'hCAFEF00D, 0);
        add(0, 32'h10,   W, 0, 32'h0,        32'hDEAD7FEF, 0);
        add(0, 32'h10,   R, 0, 32'h0,        32'h0,        1);
        add(1, 32'h10,   R, 0, 32'h0,        32'h0,        1);
        add(0, 32'h10,   W, 0, 32'h0,        32'hDEAD7FEF, 0);
        add(1, 32'h14,   W, 0, 32'h0,        32'h0,        0);
        add(1, 32'h16,   H, 0, 32'hFFFF1234, 32'h0,        0);
        add(0, 32'h14,   W, 0, 32'h0,        32'h12340000, 0);
        add(0, 32'h16,   H, 1, 32'h0,        32'h00001234, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add(0, 32'h12,   W, 0, 32'h0,        32'h0,        1);
        add(1, 32'h11,   H, 0, 32'h0000BEEF, 32'h0,        1);
        add(0, 32'h10,   W, 0, 32'h0,        32'hDEAD7FEF, 0);
        word10_final = 32'hDEAD7FEF;
`else
        add(0, 32'h12,   W, 0, 32'h0,        32'hDEAD7FEF, 0);
        add(1, 32'h11,   H, 0, 32'h0000BEEF, 32'h0,        0);
        add(0, 32'h10,   W, 0, 32'h0,        32'hDEADBEEF, 0);
        word10_final = 32'hDEADBEEF;
`endif
        add(1, 32'h20,   W, 0, 32'hAAAA5555, 32'h0,        0);

        foreach (vecs[i]) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, 0, 1'b0, $sformatf("v%0d", i));
        end

        // Back-pressure: response held for 5 cycles while a rogue request is presented
        run_req(0, 32'h12, H, 0, 32'h0, 32'hFFFFDEAD, 0, 5, 1'b1, "stall-half");
        run_req(0, 32'h10, W, 0, 32'h0, word10_final, 0, 0, 1'b0, "after-stall");

        // Reset while a store sits in WAIT: store must be discarded
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = W;
        req_unsigned = 1'b0; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid wait req_ready", 32'(req_ready), 32'd0);
        chk("mid wait rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async rst req_ready", 32'(req_ready), 32'd1);
        chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async rst rsp_rdata", rsp_rdata, 32'd0);
        chk("async rst rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(0, 32'h20, W, 0, 32'h0, 32'hAAAA5555, 0, 0, 1'b0, "post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
